// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master controller slice.
// No logic; no latency; no backpressure.
// States are ordered by transfer phase.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    XFER  = 2'd2,
    HOLD  = 2'd3
  } spi_state_t;

  localparam int SPI_N_DEF       = 8;
  localparam int SPI_CLK_DIV_DEF = 4;

endpackage

// File: rtl/spi_master_ctrl_if.sv
// Host-side word handshake between register logic and the SPI master.
// No logic; no latency; start is ignored by the controller while busy.
// The master modport belongs to the host and the slave modport to the controller.
interface spi_master_ctrl_if #(
  parameter int N = 8
);
  logic         start;
  logic [N-1:0] tx_data;
  logic         busy;
  logic         done;
  logic [N-1:0] rx_data;

  modport master (
    output start,
    output tx_data,
    input  busy,
    input  done,
    input  rx_data
  );

  modport slave (
    input  start,
    input  tx_data,
    output busy,
    output done,
    output rx_data
  );
endinterface

// File: rtl/spi_clk_div.sv
// Half-period tick generator: one strobe every CLK_DIV enabled cycles, alternating rise/fall.
// Latency: first strobe CLK_DIV cycles after clear; no backpressure (free-running while en=1).
// clr restarts both the count and the phase so the next strobe is always a rise.
module spi_clk_div #(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic rise_tick,
  output logic fall_tick
);

  localparam int CW = $clog2(CLK_DIV) + 1;

  logic [CW-1:0] cnt;
  logic          phase;
  logic          tick;

  assign tick      = en && (cnt == CW'(CLK_DIV - 1));
  assign rise_tick = tick && !phase;
  assign fall_tick = tick && phase;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      cnt   <= '0;
      phase <= 1'b0;
    end else if (tick) begin
      cnt   <= '0;
      phase <= ~phase;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: serialises one N-bit word and captures one word from miso (SPI_LSB_FIRST_EN selects LSB first).
// Latency: done (2N+2)*CLK_DIV cycles after the accepting edge; start is ignored while busy.
// Back-to-back: start in the done cycle is accepted, leaving cs_n high for one cycle.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int N       = SPI_N_DEF,
  parameter int CLK_DIV = SPI_CLK_DIV_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_master_ctrl_if.slave     host,
  output logic                 sclk,
  output logic                 cs_n,
  output logic                 mosi,
  input  logic                 miso
);

  localparam int BW = $clog2(N) + 1;

  spi_state_t    state, state_d;
  logic          div_en, div_clr;
  logic          rise_tick, fall_tick;
  logic          last_bit;
  logic [N-1:0]  tx_sr, tx_next;
  logic [N-1:0]  rx_sr, rx_next;
  logic [N-1:0]  rx_word;
  logic [BW-1:0] bit_cnt;
  logic          busy_q, done_q;

`ifdef SPI_LSB_FIRST_EN
  assign tx_next = {1'b0, tx_sr[N-1:1]};
  assign rx_next = {miso, rx_sr[N-1:1]};
  assign mosi    = !cs_n && tx_sr[0];
`else
  assign tx_next = {tx_sr[N-2:0], 1'b0};
  assign rx_next = {rx_sr[N-2:0], miso};
  assign mosi    = !cs_n && tx_sr[N-1];
`endif

  assign last_bit     = (bit_cnt == BW'(N));
  assign host.busy    = busy_q;
  assign host.done    = done_q;
  assign host.rx_data = rx_word;

  spi_clk_div #(
    .CLK_DIV (CLK_DIV)
  ) u_clk_div (
    .clk       (clk),
    .rst       (rst),
    .en        (div_en),
    .clr       (div_clr),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Every state change restarts the divider so each phase lasts whole half-periods.
  always_comb begin
    state_d = state;
    div_en  = 1'b0;
    div_clr = 1'b0;
    case (state)
      IDLE: begin
        div_clr = 1'b1;
        if (host.start) state_d = SETUP;
      end
      SETUP: begin
        div_en = 1'b1;
        if (rise_tick) state_d = XFER;
      end
      XFER: begin
        div_en = 1'b1;
        if (fall_tick && last_bit) state_d = HOLD;
      end
      HOLD: begin
        div_en = 1'b1;
        if (rise_tick) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (state_d != state) div_clr = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_sr   <= '0;
      rx_sr   <= '0;
      rx_word <= '0;
      bit_cnt <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      sclk    <= 1'b0;
      cs_n    <= 1'b1;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (host.start) begin
            tx_sr   <= host.tx_data;
            rx_sr   <= '0;
            bit_cnt <= '0;
            busy_q  <= 1'b1;
            cs_n    <= 1'b0;
          end
        end
        XFER: begin
          if (rise_tick) begin
            sclk  <= 1'b1;
            rx_sr <= rx_next;
            if (!last_bit) bit_cnt <= bit_cnt + 1'b1;
          end else if (fall_tick) begin
            sclk <= 1'b0;
            // The final bit stays on mosi through HOLD.
            if (!last_bit) tx_sr <= tx_next;
          end
        end
        HOLD: begin
          if (rise_tick) begin
            cs_n    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            rx_word <= rx_sr;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
